vec_mem_unit: RTL and testbench

- Memory-side responder for the processor control's memory handshake.
- Accepts `mem_st`/`mem_op` from decode and sequences element-wide accesses to a single-port data RAM.
- Returns `mem_rdy` to the control so it can stall the PC and execute stage, and feed the vector/scalar register write paths.
- Implements load vector, load scalar, store vector and store scalar.

---
 rtl/vec_mem_unit.sv | 78 +++++++
 tb/tb_vec_mem_unit.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/vec_mem_unit.sv
// vec_mem_unit: sequences element-wide vector/scalar loads and stores onto a single-port RAM
module vec_mem_unit #(
    parameter int NLANES = 8,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_st,
    input  logic [1:0]               mem_op,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [NLANES*DATA_W-1:0] vec_wdata,
    input  logic [DATA_W-1:0]        esc_wdata,
    output logic                     mem_rdy,
    output logic [NLANES*DATA_W-1:0] vec_rdata,
    output logic [DATA_W-1:0]        esc_rdata,
    output logic [ADDR_W-1:0]        ram_addr,
    output logic [DATA_W-1:0]        ram_wdata,
    output logic                     ram_we,
    input  logic [DATA_W-1:0]        ram_rdata
);
    localparam int IW = $clog2(NLANES + 1);
    typedef enum logic [2:0] {IDLE, RD, RWAIT, WR, DONE} state_t;
    state_t              state, state_nx;
    logic                scalar;
    logic [ADDR_W-1:0]   base;
    logic [NLANES*DATA_W-1:0] vwd;
    logic [DATA_W-1:0]   ewd;
    logic [IW-1:0]       idx, last;
    logic                accept, capture;
    assign last     = scalar ? IW'(0) : IW'(NLANES - 1);
    assign mem_rdy  = state == IDLE || state == DONE;
    assign accept   = mem_rdy && mem_st;
    assign capture  = (state == RD && idx != '0) || state == RWAIT;
    assign ram_we   = state == WR;
    assign ram_addr = (state == RD || state == WR) ? base + ADDR_W'(idx) : '0;
    assign ram_wdata = ram_we ? (scalar ? ewd : vwd[idx*DATA_W +: DATA_W]) : '0;
    // next-state: reads end with one extra cycle to catch the last RAM word
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: state_nx = mem_st ? (mem_op[1] ? RD : WR) : IDLE;
            RD:         state_nx = idx == last ? RWAIT : RD;
            RWAIT:      state_nx = DONE;
            WR:         state_nx = idx == last ? DONE : WR;
            default:    state_nx = IDLE;
        endcase
    end
    // state, latched operands, element index and read-data capture (data lags address by one cycle)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            scalar    <= 1'b0;
            base      <= '0;
            vwd       <= '0;
            ewd       <= '0;
            idx       <= '0;
            vec_rdata <= '0;
            esc_rdata <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                scalar <= mem_op[0];
                base   <= addr;
                vwd    <= vec_wdata;
                ewd    <= esc_wdata;
                idx    <= '0;
            end else if (state == RD || state == WR) begin
                idx <= idx + IW'(1);
            end
            if (capture && scalar)
                esc_rdata <= ram_rdata;
            for (int l = 0; l < NLANES; l++)
                if (capture && !scalar && IW'(l) == idx - IW'(1))
                    vec_rdata[l*DATA_W +: DATA_W] <= ram_rdata;
        end
    end
endmodule

// File: tb/tb_vec_mem_unit.sv
// tb_vec_mem_unit: scoreboard bench for vec_mem_unit with a behavioural RAM
module tb_vec_mem_unit;
    localparam int NL = 8;
    localparam int DW = 8;
    localparam int AW = 16;
    logic clk = 0;
    logic rst = 1;
    logic mem_st = 0;
    logic [1:0] mem_op = 0;
    logic [AW-1:0] addr = 0;
    logic [NL*DW-1:0] vec_wdata = 0;
    logic [DW-1:0] esc_wdata = 0;
    logic mem_rdy, ram_we;
    logic [NL*DW-1:0] vec_rdata;
    logic [DW-1:0] esc_rdata, ram_wdata, ram_rdata;
    logic [AW-1:0] ram_addr;
    bit [7:0] ram [65536];
    bit [7:0] model [65536];
    typedef struct {bit is_vec; logic [63:0] val;} exp_t;
    exp_t sb[$];
    logic [63:0] exp_vec = 0;
    logic [7:0] exp_esc = 0;
    int total = 0;
    int passed = 0;

    vec_mem_unit #(.NLANES(NL), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .mem_st(mem_st), .mem_op(mem_op), .addr(addr),
        .vec_wdata(vec_wdata), .esc_wdata(esc_wdata), .mem_rdy(mem_rdy),
        .vec_rdata(vec_rdata), .esc_rdata(esc_rdata), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
    );

    initial forever #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // synchronous single-port RAM, read data one cycle after address
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // issue one op at a negedge, check every cycle through DONE; keep holds mem_st high
    task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [63:0] vd,
                          input logic [7:0] ed, input bit keep);
        int n = op[0] ? 1 : NL;
        int low = op[1] ? n + 1 : n;
        logic [15:0] ai;
        exp_t e;
        mem_st = 1; mem_op = op; addr = a; vec_wdata = vd; esc_wdata = ed;
        e.is_vec = !op[0];
        e.val = 0;
        for (int i = 0; i < n; i++) begin
            ai = a + 16'(i);
            if (!op[1]) model[ai] = op[0] ? ed : vd[i*8 +: 8];
            else e.val[i*8 +: 8] = model[ai];
        end
        if (op[1]) begin
            sb.push_back(e);
            if (e.is_vec) exp_vec = e.val; else exp_esc = e.val[7:0];
        end
        for (int k = 0; k <= low; k++) begin
            @(negedge clk);
            if (k == 0) begin
                addr = ~a; vec_wdata = ~vd; esc_wdata = ~ed;
                if (!keep) mem_st = 0;
            end
            if (k < low) begin
                check("rdy_low", 64'(mem_rdy), 0);
                if (k < n) begin
                    ai = a + 16'(k);
                    check("ram_addr", 64'(ram_addr), 64'(ai));
                    check("ram_we", 64'(ram_we), 64'(!op[1]));
                    if (!op[1]) check("ram_wdata", 64'(ram_wdata), 64'(op[0] ? ed : vd[k*8 +: 8]));
                end
            end else begin
                check("rdy_done", 64'(mem_rdy), 1);
                check("we_done", 64'(ram_we), 0);
                if (op[1]) begin
                    if (sb.size() == 0) check("sb_empty", 1, 0);
                    else begin
                        e = sb.pop_front();
                        if (e.is_vec) check("vec_rdata", vec_rdata, e.val);
                        else check("esc_rdata", 64'(esc_rdata), e.val);
                    end
                end
                check("vec_hold", vec_rdata, exp_vec);
                check("esc_hold", 64'(esc_rdata), 64'(exp_esc));
            end
        end
    endtask

    initial begin
        logic [63:0] vd3;
        repeat (2) @(negedge clk);
        check("rst_rdy", 64'(mem_rdy), 1);
        check("rst_we", 64'(ram_we), 0);
        check("rst_vec", vec_rdata, 0);
        check("rst_esc", 64'(esc_rdata), 0);
        check("rst_addr", 64'(ram_addr), 0);
        rst = 0;
        @(negedge clk);
        check("idle_rdy", 64'(mem_rdy), 1);
        run_op(2'b00, 16'h0010, 64'h8877665544332211, 8'h00, 0);
        @(negedge clk);
        check("idle_after_st", 64'(mem_rdy), 1);
        run_op(2'b10, 16'h0010, 64'h0, 8'h00, 0);
        @(negedge clk);
        run_op(2'b01, 16'h0200, 64'h0, 8'hA5, 0);
        @(negedge clk);
        run_op(2'b11, 16'h0200, 64'h0, 8'h00, 0);
        @(negedge clk);
        run_op(2'b00, 16'hFFFE, 64'hF7E6D5C4B3A29180, 8'h00, 1);
        run_op(2'b10, 16'hFFFE, 64'h0, 8'h00, 1);
        run_op(2'b11, 16'h0001, 64'h0, 8'h00, 0);
        @(negedge clk);
        check("idle_after_chain", 64'(mem_rdy), 1);
        vd3 = 64'hC8C7C6C5C4C3C2C1;
        mem_st = 1; mem_op = 2'b00; addr = 16'h0300; vec_wdata = vd3;
        for (int k = 0; k <= 3; k++) begin
            @(negedge clk);
            mem_st = 0;
        end
        check("mid_we", 64'(ram_we), 1);
        #2 rst = 1;
        #1;
        check("abort_we", 64'(ram_we), 0);
        check("abort_rdy", 64'(mem_rdy), 1);
        check("abort_vec", vec_rdata, 0);
        check("abort_esc", 64'(esc_rdata), 0);
        check("abort_addr", 64'(ram_addr), 0);
        for (int i = 0; i < 3; i++) check("partial_wr", 64'(ram[16'h0300 + 16'(i)]), 64'(vd3[i*8 +: 8]));
        check("no_wr_idx3", 64'(ram[16'h0303]), 0);
        exp_vec = 0;
        exp_esc = 0;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        run_op(2'b11, 16'h0200, 64'h0, 8'h00, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
